// File: rtl/tx_frame_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream egress among three frame sources,
// with a per-frame beat limit (truncate, then drain the rest) and a fixed inter-frame idle gap.
//
// state    | meaning
// ST_IDLE  | no grant; pick the next valid port round-robin from rr_ptr
// ST_XFER  | granted port passed straight through to the egress
// ST_DRAIN | frame hit the beat limit; remaining source beats are discarded
// ST_GAP   | inter-frame idle gap counting down
module tx_frame_arbiter #(
  parameter int DATA_W     = 32,
  parameter int IFG_CYCLES = 2,
  parameter int MAX_BEATS  = 380
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*DATA_W-1:0]     s_tdata,
  input  logic [3*(DATA_W/8)-1:0] s_tkeep,
  input  logic [2:0]              s_tvalid,
  input  logic [2:0]              s_tlast,
  output logic [2:0]              s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic [DATA_W/8-1:0]     m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [1:0]              grant_idx,
  output logic                    busy,
  output logic                    frame_trunc
);
  localparam int KEEP_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);
  localparam logic [15:0] GAP_INIT  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
  localparam logic [1:0]  ST_AFTER  = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

  logic [1:0]        state;
  logic [1:0]        rr_ptr;
  logic [15:0]       beat_cnt;
  logic [15:0]       gap_cnt;

  logic [DATA_W-1:0] g_data;
  logic [KEEP_W-1:0] g_keep;
  logic              g_valid;
  logic              g_last;
  logic [1:0]        pick;
  logic [1:0]        p1;
  logic [1:0]        p2;
  logic [2:0]        sel;
  logic              xfer;
  logic              drain;
  logic              at_limit;

  function automatic logic [1:0] nxt(input logic [1:0] g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    case (grant_idx)
      2'd0: begin
        g_data  = s_tdata[0 +: DATA_W];
        g_keep  = s_tkeep[0 +: KEEP_W];
        g_valid = s_tvalid[0];
        g_last  = s_tlast[0];
      end
      2'd1: begin
        g_data  = s_tdata[DATA_W +: DATA_W];
        g_keep  = s_tkeep[KEEP_W +: KEEP_W];
        g_valid = s_tvalid[1];
        g_last  = s_tlast[1];
      end
      2'd2: begin
        g_data  = s_tdata[2*DATA_W +: DATA_W];
        g_keep  = s_tkeep[2*KEEP_W +: KEEP_W];
        g_valid = s_tvalid[2];
        g_last  = s_tlast[2];
      end
      default: ;
    endcase
  end

  // Round-robin scan: rr_ptr first, then the two ports after it.
  always_comb begin
    p1 = nxt(rr_ptr);
    p2 = nxt(p1);
    if (s_tvalid[rr_ptr])  pick = rr_ptr;
    else if (s_tvalid[p1]) pick = p1;
    else                   pick = p2;
  end

  assign xfer     = (state == ST_XFER);
  assign drain    = (state == ST_DRAIN);
  assign at_limit = (beat_cnt == LAST_BEAT);
  assign sel      = 3'b001 << grant_idx;

  assign m_tdata  = xfer ? g_data : '0;
  assign m_tkeep  = xfer ? g_keep : '0;
  assign m_tvalid = xfer & g_valid;
  assign m_tlast  = xfer & (g_last | at_limit);
  assign s_tready = (xfer & m_tready) ? sel : (drain ? sel : 3'b000);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= 2'd0;
      beat_cnt    <= 16'd0;
      gap_cnt     <= 16'd0;
      grant_idx   <= 2'd0;
      frame_trunc <= 1'b0;
    end else begin
      frame_trunc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|s_tvalid) begin
            grant_idx <= pick;
            beat_cnt  <= 16'd0;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (g_valid && m_tready) begin
            if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
            // tlast on the limit beat is a normal end, so it wins over truncation
            if (g_last) begin
              rr_ptr  <= nxt(grant_idx);
              gap_cnt <= GAP_INIT;
              state   <= ST_AFTER;
            end else if (at_limit) begin
              frame_trunc <= 1'b1;
              rr_ptr      <= nxt(grant_idx);
              state       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (g_valid && g_last) begin
            gap_cnt <= GAP_INIT;
            state   <= ST_AFTER;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'd0) state <= ST_IDLE;
          else                  gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed reset/IFG=0/limit cases plus randomized frame batches
// checked against a frame-level model (round-robin over pending sources, beat limit, idle gap).
`timescale 1ns/1ps
module tb_tx_frame_arbiter;
  localparam int DW   = 32;
  localparam int KW   = 4;
  localparam int IFG  = 2;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3*DW-1:0] s_tdata;
  logic [3*KW-1:0] s_tkeep;
  logic [2:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tlast, m_tready;
  logic [1:0]      grant_idx;
  logic            busy, frame_trunc;

  logic [3*DW-1:0] z_s_tdata;
  logic [3*KW-1:0] z_s_tkeep;
  logic [2:0]      z_s_tvalid, z_s_tlast, z_s_tready;
  logic [DW-1:0]   z_m_tdata;
  logic [KW-1:0]   z_m_tkeep;
  logic            z_m_tvalid, z_m_tlast, z_m_tready;
  logic [1:0]      z_grant_idx;
  logic            z_busy, z_frame_trunc;

  tx_frame_arbiter #(.DATA_W(DW), .IFG_CYCLES(IFG), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready), .grant_idx(grant_idx),
    .busy(busy), .frame_trunc(frame_trunc));

  tx_frame_arbiter #(.DATA_W(DW), .IFG_CYCLES(0), .MAX_BEATS(1)) dut_z (
    .clk(clk), .reset(reset), .s_tdata(z_s_tdata), .s_tkeep(z_s_tkeep), .s_tvalid(z_s_tvalid),
    .s_tlast(z_s_tlast), .s_tready(z_s_tready), .m_tdata(z_m_tdata), .m_tkeep(z_m_tkeep),
    .m_tvalid(z_m_tvalid), .m_tlast(z_m_tlast), .m_tready(z_m_tready), .grant_idx(z_grant_idx),
    .busy(z_busy), .frame_trunc(z_frame_trunc));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // frame-level model state
  int fl_len [3][8];
  int fl_id  [3][8];
  int n_fr   [3];
  int head   [3];
  int src_k  [3];
  int fid = 0;
  int cur = -1;
  int out_k = 0;
  int rr_ref = 0;
  int end_cyc = -100;
  int exp_start = -1;
  int trunc_cyc = -100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] bdata(input int p, input int id, input int k);
    return {4'(p + 1), 12'(id), 16'(k)};
  endfunction

  function automatic logic [3:0] bkeep(input int p, input int id, input int k);
    return 4'(((id * 7 + k * 3 + p) % 15) + 1);
  endfunction

  function automatic bit any_pending();
    for (int p = 0; p < 3; p++) if (head[p] < n_fr[p]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_pick();
    for (int i = 0; i < 3; i++) begin
      int p;
      p = (rr_ref + i) % 3;
      if (head[p] < n_fr[p]) return p;
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    z_s_tdata = '0; z_s_tkeep = '0; z_s_tvalid = '0; z_s_tlast = '0; z_m_tready = 1'b0;
  endtask

  task automatic rand_cycle();
    int clen, lim;
    logic [2:0] bit_sel;
    logic in_x;
    for (int p = 0; p < 3; p++) begin
      if (head[p] < n_fr[p]) begin
        s_tvalid[p] = (src_k[p] == 0) || ($urandom_range(0, 3) != 0);
        s_tdata[p*DW +: DW] = bdata(p, fl_id[p][head[p]], src_k[p]);
        s_tkeep[p*KW +: KW] = bkeep(p, fl_id[p][head[p]], src_k[p]);
        s_tlast[p] = (src_k[p] == fl_len[p][head[p]] - 1);
      end else begin
        s_tvalid[p] = 1'b0;
        s_tdata[p*DW +: DW] = '0;
        s_tkeep[p*KW +: KW] = '0;
        s_tlast[p] = 1'b0;
      end
    end
    m_tready = ($urandom_range(0, 9) < 7);
    #2;
    if (cur < 0) begin
      chk("m_tvalid_start", 64'(m_tvalid), 64'(cyc == exp_start));
      if (m_tvalid && any_pending()) begin
        cur = rr_pick();
        out_k = 0;
        chk("grant_idx", 64'(grant_idx), 64'(cur));
      end
    end
    in_x = 1'b0;
    clen = 0;
    if (cur >= 0) begin
      clen = fl_len[cur][head[cur]];
      lim = (clen < MAXB) ? clen : MAXB;
      bit_sel = 3'(1 << cur);
      in_x = (out_k < lim);
      if (in_x) begin
        chk("m_tvalid_xfer", 64'(m_tvalid), 64'(s_tvalid[cur]));
        chk("s_tready_xfer", 64'(s_tready), 64'(m_tready ? bit_sel : 3'b000));
        if (s_tvalid[cur]) begin
          chk("m_tdata", 64'(m_tdata), 64'(bdata(cur, fl_id[cur][head[cur]], out_k)));
          chk("m_tkeep", 64'(m_tkeep), 64'(bkeep(cur, fl_id[cur][head[cur]], out_k)));
          chk("m_tlast", 64'(m_tlast), 64'(out_k == lim - 1));
        end
      end else begin
        chk("m_tvalid_drain", 64'(m_tvalid), 64'd0);
        chk("s_tready_drain", 64'(s_tready), 64'(bit_sel));
      end
    end else begin
      chk("s_tready_idle", 64'(s_tready), 64'd0);
    end
    chk("busy", 64'(busy), 64'((cur >= 0) || (cyc > end_cyc && cyc <= end_cyc + IFG)));
    chk("frame_trunc", 64'(frame_trunc), 64'(cyc == trunc_cyc + 1));
    if (cur >= 0 && in_x && s_tvalid[cur] && m_tready) begin
      if (out_k == MAXB - 1 && clen > MAXB) trunc_cyc = cyc;
      out_k++;
    end
    for (int p = 0; p < 3; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        if (s_tlast[p]) begin
          head[p]++;
          src_k[p] = 0;
          if (p == cur) begin
            rr_ref = (p + 1) % 3;
            end_cyc = cyc;
            cur = -1;
            exp_start = any_pending() ? cyc + IFG + 2 : -1;
          end
        end else begin
          src_k[p]++;
        end
      end
    end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin n_fr[i] = 0; head[i] = 0; src_k[i] = 0; end
    tick(); tick(); tick();
    #2;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_z_busy", 64'(z_busy), 64'd0);
    reset = 1'b1;
    tick();

    // mid-frame reset on beat 2 of a port 2 frame
    s_tvalid = 3'b100; s_tdata[2*DW +: DW] = 32'hA0A0_0000; s_tkeep[2*KW +: KW] = 4'hF;
    m_tready = 1'b1;
    #2; chk("mr_idle_valid", 64'(m_tvalid), 64'd0);
    tick();
    #2;
    chk("mr_grant", 64'(grant_idx), 64'd2);
    chk("mr_beat1", 64'(m_tdata), 64'hA0A0_0000);
    chk("mr_s_tready", 64'(s_tready), 64'b100);
    tick();
    s_tdata[2*DW +: DW] = 32'hA0A0_0001;
    #2; chk("mr_beat2", 64'(m_tdata), 64'hA0A0_0001);
    reset = 1'b0;
    tick();
    #2;
    chk("mr_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mr_m_tlast", 64'(m_tlast), 64'd0);
    chk("mr_m_tdata", 64'(m_tdata), 64'd0);
    chk("mr_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("mr_s_tready", 64'(s_tready), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_trunc", 64'(frame_trunc), 64'd0);
    chk("mr_grant_rst", 64'(grant_idx), 64'd0);
    reset = 1'b1;
    s_tvalid = 3'b010; s_tlast = 3'b010;
    s_tdata[DW +: DW] = 32'hB1B1_0000; s_tkeep[KW +: KW] = 4'h3;
    tick();
    #2;
    chk("ar_grant", 64'(grant_idx), 64'd1);
    chk("ar_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("ar_m_tdata", 64'(m_tdata), 64'hB1B1_0000);
    chk("ar_m_tkeep", 64'(m_tkeep), 64'h3);
    chk("ar_m_tlast", 64'(m_tlast), 64'd1);
    tick();
    clear_inputs();
    for (int i = 0; i < 6; i++) tick();

    // IFG=0, MAX_BEATS=1 instance: back-to-back single-beat frames, then a truncation
    z_s_tvalid = 3'b011; z_s_tlast = 3'b011; z_m_tready = 1'b1;
    z_s_tdata[0 +: DW] = 32'hC0C0_0000; z_s_tkeep[0 +: KW] = 4'h1;
    z_s_tdata[DW +: DW] = 32'hC1C1_0000; z_s_tkeep[KW +: KW] = 4'h7;
    #2; chk("z_idle_valid", 64'(z_m_tvalid), 64'd0);
    tick();
    #2;
    chk("z_f0_valid", 64'(z_m_tvalid), 64'd1);
    chk("z_f0_grant", 64'(z_grant_idx), 64'd0);
    chk("z_f0_data", 64'(z_m_tdata), 64'hC0C0_0000);
    chk("z_f0_last", 64'(z_m_tlast), 64'd1);
    tick();
    z_s_tvalid = 3'b010;
    #2;
    chk("z_gap_valid", 64'(z_m_tvalid), 64'd0);
    chk("z_gap_busy", 64'(z_busy), 64'd0);
    chk("z_gap_trunc", 64'(z_frame_trunc), 64'd0);
    tick();
    #2;
    chk("z_f1_valid", 64'(z_m_tvalid), 64'd1);
    chk("z_f1_grant", 64'(z_grant_idx), 64'd1);
    chk("z_f1_data", 64'(z_m_tdata), 64'hC1C1_0000);
    chk("z_f1_keep", 64'(z_m_tkeep), 64'h7);
    tick();
    z_s_tvalid = 3'b100; z_s_tlast = 3'b000;
    z_s_tdata[2*DW +: DW] = 32'hC2C2_0000; z_s_tkeep[2*KW +: KW] = 4'hF;
    #2;
    chk("z_f1_trunc", 64'(z_frame_trunc), 64'd0);
    chk("z_f2_idle", 64'(z_m_tvalid), 64'd0);
    tick();
    #2;
    chk("z_f2_valid", 64'(z_m_tvalid), 64'd1);
    chk("z_f2_last", 64'(z_m_tlast), 64'd1);
    chk("z_f2_data", 64'(z_m_tdata), 64'hC2C2_0000);
    tick();
    z_s_tlast = 3'b100; z_m_tready = 1'b0; z_s_tdata[2*DW +: DW] = 32'hC2C2_0001;
    #2;
    chk("z_drain_trunc", 64'(z_frame_trunc), 64'd1);
    chk("z_drain_valid", 64'(z_m_tvalid), 64'd0);
    chk("z_drain_ready", 64'(z_s_tready), 64'b100);
    tick();
    z_s_tvalid = 3'b000; z_s_tlast = 3'b000;
    #2;
    chk("z_end_busy", 64'(z_busy), 64'd0);
    chk("z_end_trunc", 64'(z_frame_trunc), 64'd0);
    clear_inputs();

    // fresh reset so rr_ptr starts at 0 for the randomized batches
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    rr_ref = 0; end_cyc = -100; trunc_cyc = -100; cur = -1;

    for (int b = 0; b < 30; b++) begin
      for (int p = 0; p < 3; p++) begin
        head[p] = 0; src_k[p] = 0;
        if (b == 0) n_fr[p] = (p == 1) ? 0 : 2;
        else if (p == b % 3) n_fr[p] = $urandom_range(1, 3);
        else n_fr[p] = $urandom_range(0, 3);
        for (int f = 0; f < n_fr[p]; f++) begin
          fl_len[p][f] = (b == 0) ? 2 : $urandom_range(1, 7);
          fl_id[p][f] = fid;
          fid++;
        end
      end
      exp_start = cyc + 1;
      for (int t = 0; t < 600 && (any_pending() || cur >= 0); t++) rand_cycle();
      chk("batch_done", 64'(any_pending() || cur >= 0), 64'd0);
      for (int i = 0; i < 4; i++) rand_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
